// File: rtl/datapath_pkg.sv
// Shared definitions for the register-file + ALU datapath: ALU opcodes and
// the register values that power-up and reset both restore.
package datapath_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_NOR   = 3'b110;
  localparam logic [2:0] ALU_PASSA = 3'b111;

  localparam int NUM_REGS = 4;

  // Signed so that a width cast sign-extends -1 into all-ones at any WIDTH.
  localparam int signed RST_R0 = 0;
  localparam int signed RST_R1 = 0;
  localparam int signed RST_R2 = -1;
  localparam int signed RST_R3 = 1;

endpackage

// File: rtl/datapath_regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous
// write port, asynchronous reset to the package reset constants.
module datapath_regfile
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       raddr1,
  input  logic [1:0]       raddr2,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  // The declaration value gives correct contents at power-up even if rst
  // is never asserted; rst restores the same values.
  logic [WIDTH-1:0] register [0:NUM_REGS-1] = '{
    WIDTH'(RST_R0), WIDTH'(RST_R1), WIDTH'(RST_R2), WIDTH'(RST_R3)
  };

  assign rdata1 = register[raddr1];
  assign rdata2 = register[raddr2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      register[0] <= WIDTH'(RST_R0);
      register[1] <= WIDTH'(RST_R1);
      register[2] <= WIDTH'(RST_R2);
      register[3] <= WIDTH'(RST_R3);
    end else if (we) begin
      register[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/datapath.sv
// Register-file + ALU datapath: reads two registers, applies the selected ALU
// operation and optionally writes the result back; Zero flags a zero result.
module datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [2:0] ALUControl,
  input  logic [1:0] addr1,
  input  logic [1:0] addr2,
  input  logic [1:0] addr3,
  output logic       Zero
);

  logic [WIDTH-1:0]        rdata1;
  logic [WIDTH-1:0]        rdata2;
  logic signed [WIDTH-1:0] opa;
  logic signed [WIDTH-1:0] opb;
  logic [WIDTH-1:0]        result;

  // Results wrap modulo 2^WIDTH; only SLT needs signed interpretation.
  function automatic logic [WIDTH-1:0] alu_eval(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_SLT:   r = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_NOR:   r = ~(a | b);
      ALU_PASSA: r = a;
      default:   r = '0;
    endcase
    return r;
  endfunction

  datapath_regfile #(
    .WIDTH(WIDTH)
  ) rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wr),
    .raddr1 (addr1),
    .raddr2 (addr2),
    .waddr  (addr3),
    .wdata  (result),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  assign opa = $signed(rdata1);
  assign opb = $signed(rdata2);

  always_comb begin
    result = alu_eval(ALUControl, opa, opb);
  end

  assign Zero = (result == '0);

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: hand-computed register contents and Zero flag
// across power-up operation, every ALU op, write-disable and async reset.
module tb_datapath;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SLT = 3'b101,
                         OP_NOR = 3'b110, OP_PSA = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] ALUControl = 3'b000;
  logic [1:0] addr1 = 2'd0;
  logic [1:0] addr2 = 2'd0;
  logic [1:0] addr3 = 2'd0;
  logic       Zero;

  int checks = 0;
  int fails  = 0;

  datapath #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .ALUControl (ALUControl),
    .addr1      (addr1),
    .addr2      (addr2),
    .addr3      (addr3),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a new operation just after the falling edge.
  task automatic drive(input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3,
                       input logic [2:0] op, input logic w);
    @(negedge clk);
    addr1 = a1; addr2 = a2; addr3 = a3; ALUControl = op; wr = w;
    #1;
  endtask

  // Let one rising edge pass, then drop the write enable.
  task automatic edge_pass();
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
    check({tag, ".R0"}, dut.rf.register[0], r0);
    check({tag, ".R1"}, dut.rf.register[1], r1);
    check({tag, ".R2"}, dut.rf.register[2], r2);
    check({tag, ".R3"}, dut.rf.register[3], r3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-up contents, rst never asserted
    #1;
    check_regs("powerup", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1);

    // R1 <= R1 - R1
    drive(2'd1, 2'd1, 2'd1, OP_SUB, 1'b1);
    check("sub_r1_zero", Zero, 1'b1);
    edge_pass();
    check("sub_r1_val", dut.rf.register[1], 32'h0);

    // R0 <= R2 + R1
    drive(2'd2, 2'd1, 2'd0, OP_ADD, 1'b1);
    check("add_r0_zero", Zero, 1'b0);
    edge_pass();
    check("add_r0_val", dut.rf.register[0], 32'hFFFF_FFFF);

    // R2 <= R1 - R3 wraps to all-ones
    drive(2'd1, 2'd3, 2'd2, OP_SUB, 1'b1);
    check("sub_r2_zero", Zero, 1'b0);
    edge_pass();
    check("sub_r2_val", dut.rf.register[2], 32'hFFFF_FFFF);

    // R3 <= R0 + R3 carries out to zero
    drive(2'd0, 2'd3, 2'd3, OP_ADD, 1'b1);
    check("add_r3_zero", Zero, 1'b1);
    edge_pass();
    check("add_r3_val", dut.rf.register[3], 32'h0);
    check("add_r3_zero_after", Zero, 1'b0);

    // wr=0: Zero follows operands (R0=-1, R1=0, R2=-1, R3=0)
    drive(2'd0, 2'd1, 2'd2, OP_AND, 1'b0);  check("nw_and",     Zero, 1'b1);
    drive(2'd0, 2'd1, 2'd2, OP_OR,  1'b0);  check("nw_or",      Zero, 1'b0);
    drive(2'd0, 2'd2, 2'd1, OP_XOR, 1'b0);  check("nw_xor",     Zero, 1'b1);
    drive(2'd1, 2'd3, 2'd0, OP_NOR, 1'b0);  check("nw_nor00",   Zero, 1'b0);
    drive(2'd0, 2'd1, 2'd3, OP_NOR, 1'b0);  check("nw_nor_f0",  Zero, 1'b1);
    drive(2'd0, 2'd1, 2'd1, OP_SLT, 1'b0);  check("nw_slt_m1_0", Zero, 1'b0);
    drive(2'd1, 2'd0, 2'd2, OP_SLT, 1'b0);  check("nw_slt_0_m1", Zero, 1'b1);
    drive(2'd1, 2'd0, 2'd0, OP_PSA, 1'b0);  check("nw_pass0",   Zero, 1'b1);
    drive(2'd0, 2'd1, 2'd3, OP_PSA, 1'b0);  check("nw_passf",   Zero, 1'b0);
    drive(2'd0, 2'd2, 2'd0, OP_SUB, 1'b0);  check("nw_sub",     Zero, 1'b1);
    edge_pass();
    check_regs("nowrite", 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0);

    // Written results of the remaining ops
    drive(2'd0, 2'd3, 2'd1, OP_SLT, 1'b1);  edge_pass();  // R1 = (-1 < 0) = 1
    check("slt_r1", dut.rf.register[1], 32'h1);
    drive(2'd1, 2'd1, 2'd3, OP_ADD, 1'b1);  edge_pass();  // R3 = 1 + 1 = 2
    check("add_r3", dut.rf.register[3], 32'h2);
    drive(2'd3, 2'd1, 2'd2, OP_XOR, 1'b1);  edge_pass();  // R2 = 2 ^ 1 = 3
    check("xor_r2", dut.rf.register[2], 32'h3);
    drive(2'd2, 2'd3, 2'd0, OP_AND, 1'b1);  edge_pass();  // R0 = 3 & 2 = 2
    check("and_r0", dut.rf.register[0], 32'h2);
    drive(2'd2, 2'd0, 2'd1, OP_NOR, 1'b1);  edge_pass();  // R1 = ~(3 | 2)
    check("nor_r1", dut.rf.register[1], 32'hFFFF_FFFC);
    drive(2'd1, 2'd2, 2'd3, OP_SLT, 1'b1);  edge_pass();  // R3 = (-4 < 3) = 1
    check("slt_r3", dut.rf.register[3], 32'h1);
    drive(2'd1, 2'd0, 2'd3, OP_PSA, 1'b1);  edge_pass();  // R3 = R1
    check("pass_r3", dut.rf.register[3], 32'hFFFF_FFFC);
    drive(2'd2, 2'd3, 2'd2, OP_OR, 1'b1);   edge_pass();  // R2 = 3 | FFFFFFFC
    check("or_r2", dut.rf.register[2], 32'hFFFF_FFFF);
    check_regs("prereset", 32'h2, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFC);

    // Async reset mid-cycle while a write is pending
    drive(2'd1, 2'd1, 2'd0, OP_ADD, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_regs("rst_immediate", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1);
    @(posedge clk);
    #1;
    check_regs("rst_held_edge", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1);
    addr1 = 2'd0; addr2 = 2'd0; ALUControl = OP_ADD; wr = 1'b0;
    #1;
    check("rst_zero_r0r0", Zero, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Normal writes resume after reset: R0 <= R3 + R3
    drive(2'd3, 2'd3, 2'd0, OP_ADD, 1'b1);
    check("post_rst_zero", Zero, 1'b0);
    edge_pass();
    check("post_rst_r0", dut.rf.register[0], 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
